// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the IF-stage, MEM-stage and unified-memory signals that meet at the
// memory port arbiter.
//   IF side  : flush, if_req, if_addr -> if_rdata, if_ready, stall_if
//   MEM side : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ready,
//              stall_mem
//   RAM side : ram_req, ram_we, ram_addr, ram_wdata -> ram_rdata, ram_ack
// Modport slave is the arbiter view; modport master is the CPU/memory view.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// load/store (MEM). One transaction at a time; MEM normally wins, but after
// STARVE_MAX consecutive MEM grants with IF waiting, IF is forced in.
// A flush during a fetch lets the memory access finish but hides its result.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : mem_port_arbiter_if.slave (IF, MEM and RAM handshakes)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mem_port_arbiter_if.slave    io_bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_kill;
  logic [CNT_W-1:0]  r_starve_cnt;

  logic w_if_starved;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_done;
  logic w_if_ready;
  logic w_mem_ready;

  // IF has waited through the maximum run of MEM grants and must go next.
  assign w_if_starved = io_bus.if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // Next-state and grant decode; grants are only issued from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.mem_req && !w_if_starved) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ST_BUSY_MEM;
        end else if (io_bus.if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_BUSY_IF;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (io_bus.ram_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, memory request fields, fetch-kill flag and starvation counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_kill       <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_mem) begin
        r_ram_req   <= 1'b1;
        r_ram_we    <= io_bus.mem_we;
        r_ram_addr  <= io_bus.mem_addr;
        r_ram_wdata <= io_bus.mem_wdata;
        if (!io_bus.if_req) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
          r_starve_cnt <= r_starve_cnt;
        end
      end else if (w_grant_if) begin
        r_ram_req    <= 1'b1;
        r_ram_we     <= 1'b0;
        r_ram_addr   <= io_bus.if_addr;
        r_starve_cnt <= '0;
      end else if (w_done) begin
        r_ram_req <= 1'b0;
        r_kill    <= 1'b0;
      end else if ((r_state == ST_BUSY_IF) && io_bus.flush) begin
        // Memory cannot abort; remember to drop the result when it arrives.
        r_kill <= 1'b1;
      end else begin
        r_kill <= r_kill;
      end
    end
  end

  // A same-cycle flush also hides the returning fetch.
  assign w_if_ready  = (r_state == ST_BUSY_IF) && io_bus.ram_ack && !r_kill && !io_bus.flush;
  assign w_mem_ready = (r_state == ST_BUSY_MEM) && io_bus.ram_ack;

  assign io_bus.if_ready  = w_if_ready;
  assign io_bus.mem_ready = w_mem_ready;
  assign io_bus.if_rdata  = w_if_ready ? io_bus.ram_rdata : {DATA_W{1'b0}};
  // Stores return zero data.
  assign io_bus.mem_rdata = (w_mem_ready && !r_ram_we) ? io_bus.ram_rdata : {DATA_W{1'b0}};
  assign io_bus.stall_if  = io_bus.if_req && !w_if_ready;
  assign io_bus.stall_mem = io_bus.mem_req && !w_mem_ready;
  assign io_bus.ram_req   = r_ram_req;
  assign io_bus.ram_we    = r_ram_we;
  assign io_bus.ram_addr  = r_ram_addr;
  assign io_bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (STARVE_MAX=4). Inputs change 1 ns after
// the rising edge; outputs are checked 1 ns after that.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_vec++; if (bus.ram_req !== 1'b0) begin n_err++; $display("FAIL rst_ram_req: got %0b want 0", bus.ram_req); end
    n_vec++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %0b want 0", bus.ram_we); end
    n_vec++; if (bus.ram_addr !== 32'h0) begin n_err++; $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); end
    n_vec++; if (bus.ram_wdata !== 32'h0) begin n_err++; $display("FAIL rst_ram_wdata: got %h want 0", bus.ram_wdata); end
    n_vec++; if (int'(dut.r_starve_cnt) !== 0) begin n_err++; $display("FAIL rst_starve: got %0d want 0", dut.r_starve_cnt); end
    rst = 1'b0;
    // Stale acknowledge in IDLE must not produce a ready pulse.
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL stale_ack_ready: got if=%0b mem=%0b want 0 0", bus.if_ready, bus.mem_ready); end
    n_vec++; if (bus.mem_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin n_err++; $display("FAIL stale_ack_rdata: got %h/%h want 0/0", bus.if_rdata, bus.mem_rdata); end
    tick();
    bus.ram_ack = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0) begin n_err++; $display("FAIL stale_ack_idle: ram_req got %0b want 0", bus.ram_req); end
  endtask

  task automatic test_single_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    #1;
    n_vec++; if (bus.stall_if !== 1'b1 || bus.ram_req !== 1'b0) begin n_err++; $display("FAIL fetch_idle: stall_if=%0b ram_req=%0b want 1 0", bus.stall_if, bus.ram_req); end
    tick();
    n_vec++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ram_we !== 1'b0) begin n_err++; $display("FAIL fetch_issue: req=%0b addr=%h we=%0b want 1 100 0", bus.ram_req, bus.ram_addr, bus.ram_we); end
    n_vec++; if (bus.if_ready !== 1'b0 || bus.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_wait: ready=%0b stall=%0b want 0 1", bus.if_ready, bus.stall_if); end
    tick();
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (bus.ram_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_2nd: got %0b want 1", bus.ram_req); end
    n_vec++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_ready: ready=%0b data=%h want 1 deadbeef", bus.if_ready, bus.if_rdata); end
    n_vec++; if (bus.stall_if !== 1'b0 || bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL fetch_stall_done: stall=%0b mem_ready=%0b want 0 0", bus.stall_if, bus.mem_ready); end
    tick();
    bus.ram_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0 || bus.if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_end: req=%0b ready=%0b want 0 0", bus.ram_req, bus.if_ready); end
  endtask

  task automatic test_simultaneous();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0104;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0200;
    tick();
    n_vec++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h200 || bus.ram_we !== 1'b0) begin n_err++; $display("FAIL simul_mem_first: req=%0b addr=%h we=%0b want 1 200 0", bus.ram_req, bus.ram_addr, bus.ram_we); end
    n_vec++; if (int'(dut.r_starve_cnt) !== 1) begin n_err++; $display("FAIL simul_starve_1: got %0d want 1", dut.r_starve_cnt); end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h55AA_0001;
    #1;
    n_vec++; if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h55AA_0001 || bus.if_ready !== 1'b0) begin n_err++; $display("FAIL simul_load: mr=%0b data=%h ir=%0b want 1 55aa0001 0", bus.mem_ready, bus.mem_rdata, bus.if_ready); end
    n_vec++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0) begin n_err++; $display("FAIL simul_stalls: si=%0b sm=%0b want 1 0", bus.stall_if, bus.stall_mem); end
    tick();
    bus.ram_ack = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0) begin n_err++; $display("FAIL simul_idle_gap: ram_req got %0b want 0", bus.ram_req); end
    tick();
    n_vec++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h104) begin n_err++; $display("FAIL simul_if_grant: req=%0b addr=%h want 1 104", bus.ram_req, bus.ram_addr); end
    n_vec++; if (int'(dut.r_starve_cnt) !== 0) begin n_err++; $display("FAIL simul_starve_0: got %0d want 0", dut.r_starve_cnt); end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0000_1104;
    #1;
    n_vec++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0000_1104) begin n_err++; $display("FAIL simul_if_ready: ready=%0b data=%h want 1 00001104", bus.if_ready, bus.if_rdata); end
    tick();
    bus.ram_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_mem [6];
    exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0600;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0500;
    for (int g = 0; g < 6; g++) begin
      int w;
      w = 0;
      tick();
      while (bus.ram_req !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      n_vec++; if (bus.ram_req !== 1'b1) begin n_err++; $display("FAIL starve_timeout: grant %0d ram_req got %0b want 1", g, bus.ram_req); end
      n_vec++; if (bus.ram_addr !== (exp_mem[g] ? 32'h500 : 32'h600)) begin n_err++; $display("FAIL starve_order: grant %0d addr got %h want %h", g, bus.ram_addr, exp_mem[g] ? 32'h500 : 32'h600); end
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'hA000_0000 + 32'(g);
      #1;
      n_vec++; if (bus.mem_ready !== exp_mem[g] || bus.if_ready !== !exp_mem[g]) begin n_err++; $display("FAIL starve_ready: grant %0d mr=%0b ir=%0b want %0b %0b", g, bus.mem_ready, bus.if_ready, exp_mem[g], !exp_mem[g]); end
      tick();
      bus.ram_ack = 1'b0;
      if (g == 5) begin
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_flush_kill();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0300;
    tick();
    n_vec++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h300) begin n_err++; $display("FAIL flush_issue: req=%0b addr=%h want 1 300", bus.ram_req, bus.ram_addr); end
    tick();
    bus.flush  = 1'b1;
    bus.if_req = 1'b0;
    #1;
    n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL flush_cycle_ready: got %0b want 0", bus.if_ready); end
    tick();
    bus.flush     = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hBAD0_BAD0;
    #1;
    n_vec++; if (bus.if_ready !== 1'b0 || bus.if_rdata !== 32'h0) begin n_err++; $display("FAIL flush_killed: ready=%0b data=%h want 0 0", bus.if_ready, bus.if_rdata); end
    tick();
    bus.ram_ack = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0 || dut.r_state !== 2'd0) begin n_err++; $display("FAIL flush_idle: req=%0b state=%0d want 0 0", bus.ram_req, dut.r_state); end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0400;
    tick();
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0400_C0DE;
    #1;
    n_vec++; if (bus.ram_addr !== 32'h400 || bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0400_C0DE) begin n_err++; $display("FAIL flush_refetch: addr=%h ready=%0b data=%h want 400 1 0400c0de", bus.ram_addr, bus.if_ready, bus.if_rdata); end
    tick();
    bus.ram_ack = 1'b0;
    // Flush coinciding with the acknowledge.
    bus.if_addr = 32'h0000_0404;
    tick();
    bus.ram_ack = 1'b1;
    bus.flush   = 1'b1;
    #1;
    n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL flush_same_cycle: ready got %0b want 0", bus.if_ready); end
    tick();
    bus.ram_ack = 1'b0;
    bus.flush   = 1'b0;
    bus.if_req  = 1'b0;
    tick();
  endtask

  task automatic test_store();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0080;
    bus.mem_wdata = 32'h0000_1234;
    tick();
    n_vec++; if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h1234 || bus.ram_addr !== 32'h80) begin n_err++; $display("FAIL store_issue: we=%0b wdata=%h addr=%h want 1 1234 80", bus.ram_we, bus.ram_wdata, bus.ram_addr); end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h7777_7777;
    #1;
    n_vec++; if (bus.mem_ready !== 1'b1 || bus.if_ready !== 1'b0) begin n_err++; $display("FAIL store_ready: mr=%0b ir=%0b want 1 0", bus.mem_ready, bus.if_ready); end
    tick();
    bus.ram_ack = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0 || bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL store_end: req=%0b mr=%0b want 0 0", bus.ram_req, bus.mem_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0700;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0090;
    tick();
    n_vec++; if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h90 || int'(dut.r_starve_cnt) !== 1) begin n_err++; $display("FAIL rmid_busy: req=%0b addr=%h cnt=%0d want 1 90 1", bus.ram_req, bus.ram_addr, dut.r_starve_cnt); end
    rst = 1'b1;
    tick();
    n_vec++; if (bus.ram_req !== 1'b0 || int'(dut.r_starve_cnt) !== 0) begin n_err++; $display("FAIL rmid_reset: req=%0b cnt=%0d want 0 0", bus.ram_req, dut.r_starve_cnt); end
    rst          = 1'b0;
    bus.mem_req  = 1'b0;
    bus.if_req   = 1'b0;
    bus.ram_ack  = 1'b1;
    bus.ram_rdata = 32'h1111_2222;
    #1;
    n_vec++; if (bus.mem_ready !== 1'b0 || bus.if_ready !== 1'b0) begin n_err++; $display("FAIL rmid_late_ack: mr=%0b ir=%0b want 0 0", bus.mem_ready, bus.if_ready); end
    tick();
    bus.ram_ack = 1'b0;
    #1;
    n_vec++; if (bus.ram_req !== 1'b0) begin n_err++; $display("FAIL rmid_idle: req=%0b want 0", bus.ram_req); end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.ram_rdata = 32'h0;
    bus.ram_ack   = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush_kill();
    test_store();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
